// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle for instr_fetch_unit: controller request, memory port and IR hand-off.
// The design binds to the slave modport and the environment driving it binds to the master modport.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fetch_start;
  logic              flush;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_load;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [DATA_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;
  logic              busy;
  logic              fetch_err;

  modport slave (
    input  fetch_start, flush, pc_in, mem_data, mem_ready, ir_ready,
    output pc_next, pc_load, mem_addr, mem_read, ir_out, ir_valid, busy, fetch_err
  );

  modport master (
    output fetch_start, flush, pc_in, mem_data, mem_ready, ir_ready,
    input  pc_next, pc_load, mem_addr, mem_read, ir_out, ir_valid, busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues a read at the PC, latches the word, hands it over and pulses PC+1.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT cycles with a fetch_err pulse.
//
// state | meaning
// IDLE  | no fetch outstanding, ir_out not offered
// WAIT  | read request driven, waiting for mem_ready
// HOLD  | instruction latched, offered until ir_ready
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;

  // The wait counter is 8 bits wide, so the limit has to fit it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must lie in 1..255 to fit the wait counter");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      bus.mem_addr  <= '0;
      bus.mem_read  <= 1'b0;
      bus.ir_out    <= '0;
      bus.ir_valid  <= 1'b0;
      bus.pc_load   <= 1'b0;
      bus.pc_next   <= '0;
      bus.busy      <= 1'b0;
      bus.fetch_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt    <= '0;
`endif
    end else begin
      bus.pc_load   <= 1'b0;
      bus.fetch_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.fetch_start && !bus.flush) begin
            r_state      <= S_WAIT;
            bus.mem_addr <= bus.pc_in;
            bus.mem_read <= 1'b1;
            bus.busy     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            r_state      <= S_IDLE;
            bus.mem_read <= 1'b0;
            bus.busy     <= 1'b0;
          end else if (bus.mem_ready) begin
            r_state      <= S_HOLD;
            bus.ir_out   <= bus.mem_data;
            bus.ir_valid <= 1'b1;
            bus.mem_read <= 1'b0;
            bus.busy     <= 1'b0;
            bus.pc_load  <= 1'b1;
            bus.pc_next  <= bus.mem_addr + ADDR_W'(1);
`ifdef FETCH_TIMEOUT_EN
          end else if (r_wait_cnt == TMO_LAST) begin
            r_state       <= S_IDLE;
            bus.mem_read  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.fetch_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
          end
        end
        S_HOLD: begin
          if (bus.flush) begin
            r_state      <= S_IDLE;
            bus.ir_valid <= 1'b0;
          end else if (bus.ir_ready) begin
            bus.ir_valid <= 1'b0;
            // Back-to-back fetch skips the IDLE bubble.
            if (bus.fetch_start) begin
              r_state      <= S_WAIT;
              bus.mem_addr <= bus.pc_in;
              bus.mem_read <= 1'b1;
              bus.busy     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              r_wait_cnt   <= '0;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer side of the program-counter path: takes the current PC value, issues a memory read, captures the returned instruction word and offers it to the controller over a valid/ready handshake.
- Drives the PC update: a one-cycle load pulse carrying PC+1.
- Sits between the program counter, instruction memory port and the control unit of the SAYEH datapath.

Parameters:
- ADDR_W, 16, width of PC/memory address
- DATA_W, 16, width of instruction word
- TIMEOUT, 255, WAIT-state cycles before abort (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_start  input  1  controller requests fetch at pc_in
- flush  input  1  synchronous abort of any fetch in progress
- pc_in  input  ADDR_W  current PC value
- pc_next  output  ADDR_W  captured address + 1, valid while pc_load=1
- pc_load  output  1  one-cycle enable to PC register
- mem_addr  output  ADDR_W  instruction memory address
- mem_read  output  1  memory read request
- mem_data  input  DATA_W  memory read data
- mem_ready  input  1  memory data valid
- ir_out  output  DATA_W  latched instruction
- ir_valid  output  1  ir_out holds unconsumed instruction
- ir_ready  input  1  controller accepts ir_out
- busy  output  1  high in WAIT
- fetch_err  output  1  one-cycle timeout pulse

Behaviour:
- Reset (rst_n=0, async): state IDLE; mem_addr=0, mem_read=0, ir_out=0, ir_valid=0, pc_load=0, pc_next=0, busy=0, fetch_err=0.
- All outputs registered.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - fetch_start=1 at edge → WAIT; mem_addr<=pc_in; mem_read<=1; busy<=1.
- WAIT:
  - mem_read/mem_addr held stable until mem_ready; fetch_start ignored.
  - mem_ready=1 at edge → HOLD: ir_out<=mem_data; ir_valid<=1; mem_read<=0; busy<=0; pc_load<=1 for exactly one cycle; pc_next<=mem_addr+1 (mod 2^ADDR_W, 0xFFFF→0x0000).
  - Minimum latency: fetch_start edge to ir_valid = 2 cycles when mem_ready is already high on the first WAIT cycle.
- HOLD:
  - ir_valid=1; ir_out stable.
  - ir_ready=1 at edge: ir_valid<=0 → IDLE.
  - ir_ready and fetch_start together → WAIT directly, mem_addr<=pc_in (back-to-back fetch, no IDLE bubble).
  - mem_ready ignored.
- flush (priority over all events except reset):
  - In WAIT: mem_read<=0, busy<=0, returned data discarded, no pc_load → IDLE.
  - In HOLD: ir_valid<=0 → IDLE; ir_out keeps last value.
  - In IDLE: no effect; fetch_start in same cycle ignored.
  - A pc_load pulse already asserted completes normally.
- Reset mid-WAIT or mid-HOLD: immediate return to reset values; outstanding memory response ignored.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter cleared on entry to WAIT, increments each WAIT cycle without mem_ready.
  - On reaching TIMEOUT: fetch_err=1 for one cycle, mem_read<=0, busy<=0, no pc_load → IDLE.
  - mem_ready on the same edge as timeout wins (normal capture, no error).
- Undefined: no counter; WAIT persists indefinitely; fetch_err tied 0.

Test Plan:
- Reset then pc_in=0x0010, fetch_start pulse, mem_ready=1 next cycle with mem_data=0xA5C3 → mem_addr=0x0010, mem_read high one cycle; ir_out=0xA5C3, ir_valid=1; pc_load one cycle with pc_next=0x0011.
- Delayed memory: mem_ready held low 5 cycles → mem_read/mem_addr stable 6 cycles, busy=1 throughout, single capture, single pc_load.
- Back-to-back: in HOLD, ir_ready=1 and fetch_start=1 with pc_in=0x0011 → same edge enters WAIT, mem_addr=0x0011, ir_valid drops.
- Wrap: pc_in=0xFFFF fetched → pc_next=0x0000 with pc_load pulse.
- flush asserted during WAIT, mem_ready=1 same cycle with 0x1234 → IDLE, ir_valid=0, no pc_load, ir_out unchanged; rst_n low mid-HOLD → all outputs 0 immediately.
- FETCH_TIMEOUT_EN, TIMEOUT=4, mem_ready never asserted → fetch_err one-cycle pulse after 4 WAIT cycles, mem_read=0, state IDLE, no pc_load.
